// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, group-count helper and stage-1 side-band payload
// for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int groups_f(input int width, input int group);
        return width / group;
    endfunction

    // Width-independent part of the stage-1 payload; the vector fields live in the top.
    typedef struct packed {
        logic c0;
        logic a_msb;
        logic b_msb;
    } s1_meta_t;

endpackage

// File: rtl/cla_group.sv
// cla_group: GROUP-bit lookahead cell giving group propagate/generate and,
// from a carry-in, the group's sum bits and carry-out.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p_i,
    input  logic [GROUP-1:0] g_i,
    input  logic             c_i,
    output logic             gp_o,
    output logic             gg_o,
    output logic [GROUP-1:0] s_o,
    output logic             c_o
);

    logic [GROUP:0] c;

    always_comb begin
        c[0] = c_i;
        gg_o = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g_i[i] | (p_i[i] & c[i]);
            gg_o   = g_i[i] | (p_i[i] & gg_o);
        end
    end

    assign gp_o = &p_i;
    assign s_o  = p_i ^ c[GROUP-1:0];
    assign c_o  = c[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes; stage 1 forms p/g and group P/G, stage 2 resolves carries.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int GROUPS = groups_f(WIDTH, GROUP);

    if (WIDTH < 2 || WIDTH % GROUP != 0) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be >= 2 and a multiple of GROUP");
    end

    typedef struct packed {
        logic [WIDTH-1:0]  p;
        logic [WIDTH-1:0]  g;
        logic [GROUPS-1:0] gp;
        logic [GROUPS-1:0] gg;
        s1_meta_t          meta;
    } s1_t;

    s1_t              s1_d, s1_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] b_eff;
    logic [GROUPS-1:0] gp1, gg1;
    logic [WIDTH-1:0] unused_s1;
    logic [GROUPS-1:0] unused_c1, unused_gp2, unused_gg2, unused_c2;
    logic [GROUPS:0]  gc;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d;
    logic             out_valid_q, cout_q, ovf_q;
    logic [WIDTH-1:0] sum_q;
    logic             s1_adv, s2_adv;

    assign s2_adv     = !out_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv;

    assign b_eff = (sub_i == MODE_SUB) ? ~b_i : b_i;

    always_comb begin
        s1_d            = '0;
        s1_d.p          = a_i ^ b_eff;
        s1_d.g          = a_i & b_eff;
        s1_d.gp         = gp1;
        s1_d.gg         = gg1;
        s1_d.meta.c0    = (sub_i == MODE_SUB) ? 1'b1 : cin_i;
        s1_d.meta.a_msb = a_i[WIDTH-1];
        s1_d.meta.b_msb = b_eff[WIDTH-1];
    end

    for (genvar k = 0; k < GROUPS; k++) begin : g_s1
        cla_group #(.GROUP(GROUP)) u_grp (
            .p_i  (s1_d.p[k*GROUP +: GROUP]),
            .g_i  (s1_d.g[k*GROUP +: GROUP]),
            .c_i  (1'b0),
            .gp_o (gp1[k]),
            .gg_o (gg1[k]),
            .s_o  (unused_s1[k*GROUP +: GROUP]),
            .c_o  (unused_c1[k])
        );
    end

    // Second-level lookahead: group carries come only from registered group P/G.
    always_comb begin
        gc[0] = s1_q.meta.c0;
        for (int k = 0; k < GROUPS; k++) begin
            gc[k+1] = s1_q.gg[k] | (s1_q.gp[k] & gc[k]);
        end
    end

    for (genvar k = 0; k < GROUPS; k++) begin : g_s2
        cla_group #(.GROUP(GROUP)) u_grp (
            .p_i  (s1_q.p[k*GROUP +: GROUP]),
            .g_i  (s1_q.g[k*GROUP +: GROUP]),
            .c_i  (gc[k]),
            .gp_o (unused_gp2[k]),
            .gg_o (unused_gg2[k]),
            .s_o  (sum_d[k*GROUP +: GROUP]),
            .c_o  (unused_c2[k])
        );
    end

    assign cout_d = gc[GROUPS];
    assign ovf_d  = (s1_q.meta.a_msb == s1_q.meta.b_msb) && (sum_d[WIDTH-1] != s1_q.meta.a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) s1_q <= s1_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized and directed streaming checks against an
// arithmetic reference model with an in-flight scoreboard.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, cout, ovf;

    logic        iv5 = 1'b0, ir5, cin5 = 1'b0, sub5 = 1'b0, ov5, or5 = 1'b1, cout5, ovf5;
    logic [4:0]  a5 = '0, b5 = '0, sum5;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, checks = 0, errors = 0, n = 0;
    logic accepted = 1'b0, lat_chk = 1'b1;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
    );

    cla_pipe_adder #(.WIDTH(5), .GROUP(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv5), .in_ready_o(ir5),
        .a_i(a5), .b_i(b5), .cin_i(cin5), .sub_i(sub5), .out_valid_o(ov5),
        .out_ready_i(or5), .sum_o(sum5), .cout_o(cout5), .ovf_o(ovf5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        exp_t e;
        int sx = $signed(x);
        int sy = $signed(y);
        int r  = s ? sx - sy : sx + sy + int'(c);
        e.sum  = s ? 16'(x - y) : 16'(x + y + 16'(c));
        e.cout = s ? (x >= y) : ((int'(x) + int'(y) + int'(c)) > 65535);
        e.ovf  = (r > 32767) || (r < -32768);
        e.t    = 0;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        #1;
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (out_valid) begin
            if (q.size() == 0) check("spurious_out", 1, 0);
            else begin
                check("sum", sum, q[0].sum);
                check("cout", cout, q[0].cout);
                check("ovf", ovf, q[0].ovf);
                if (out_ready) begin
                    if (lat_chk) check("latency", cyc - q[0].t, 2);
                    void'(q.pop_front());
                end
            end
        end else if (lat_chk && q.size() > 0 && cyc - q[0].t >= 2) check("out_valid", 0, 1);
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = model(a, b, cin, sub);
            e.t = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        int k = 0;
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        do begin tick(); k++; end while (!accepted && k < 20);
        if (!accepted) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 20) begin tick(); k++; end
        check("drain", q.size(), 0);
    endtask

    task automatic rand_beat();
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5-bit single-group instance
        a5 = 5'd12; b5 = 5'd19; iv5 = 1'b1;
        #1 check("w5_in_ready", ir5, 1);
        @(negedge clk); cin5 = 1'b1;
        @(negedge clk); iv5 = 1'b0;
        #1;
        check("w5_valid0", ov5, 1);
        check("w5_sum0", sum5, 31);
        check("w5_cout0", cout5, 0);
        check("w5_ovf0", ovf5, 0);
        @(negedge clk); #1;
        check("w5_valid1", ov5, 1);
        check("w5_sum1", sum5, 0);
        check("w5_cout1", cout5, 1);
        check("w5_ovf1", ovf5, 0);
        @(negedge clk);

        // directed boundary beats
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
        send(16'h0005, 16'h0009, 1'b1, 1'b1); drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); drain();

        // backpressure: out_ready low for cycles 2..6 of a 4-beat stream
        lat_chk = 1'b0;
        n = 0;
        rand_beat();
        for (int i = 0; i < 20; i++) begin
            out_ready = !(i >= 2 && i <= 6);
            in_valid  = (n < 4);
            tick();
            if (accepted) begin n++; rand_beat(); end
            if (i == 6) check("bp_accepted", n, 2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_sent", n, 4);
        drain();

        // full throughput
        lat_chk = 1'b1;
        n = 0;
        in_valid = 1'b1;
        rand_beat();
        for (int i = 0; i < 32; i++) begin
            tick();
            if (accepted) n++;
            rand_beat();
        end
        in_valid = 1'b0;
        check("tp_accepted", n, 32);
        drain();

        // reset with both stages full
        lat_chk = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        rand_beat();
        n = 0;
        while (q.size() < 2 && n < 10) begin tick(); rand_beat(); n++; end
        in_valid = 1'b0;
        check("mid_full", q.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; lat_chk = 1'b1;
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
